// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: CLKDV is started and stopped on whole periods, and ratio changes use a REQ/ACK handshake.
// Optional PERIOD_CNT output is enabled by defining CLKDIV_PERIOD_CNT_EN.
module clkdiv_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 10,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic             CLKIN,
  input  logic             CDRST_N,
  input  logic             DIV_EN,
  input  logic             CFG_REQ,
  input  logic [CNT_W-1:0] CFG_DIV,
  output logic             CFG_ACK,
  output logic             CFG_ERR,
  output logic             CLKDV,
  output logic             CLKDV_RISE,
  output logic             LOCKED,
  output logic [CNT_W-1:0] CUR_DIV
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [15:0]      PERIOD_CNT
`endif
);

  localparam logic [CNT_W-1:0] DEFAULT_DIV_C = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV_C     = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] ONE_C         = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             clkdv_q, clkdv_d;
  logic             rise_q, rise_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic             req_take;
  logic             req_bad;

  // (N+1)/2 is formed as N/2 + N[0] so it cannot overflow at the largest ratio.
  assign low_len  = cur_div_q >> 1;
  assign high_len = low_len + {{(CNT_W-1){1'b0}}, cur_div_q[0]};

  assign req_take = CFG_REQ && !ack_q && !pend_q;
  assign req_bad  = (CFG_DIV < MIN_DIV_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    clkdv_d    = clkdv_q;
    rise_d     = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked_q;

    unique case (state_q)
      IDLE: begin
        // A legal ratio is loaded first so a start on the same edge uses it.
        if (req_take) begin
          ack_d = 1'b1;
          err_d = req_bad;
          if (!req_bad) cur_div_d = CFG_DIV;
        end
        if (DIV_EN) begin
          state_d = RUN;
          clkdv_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = ONE_C;
        end
      end

      RUN: begin
        if (clkdv_q) begin
          if (cnt_q == high_len) begin
            clkdv_d = 1'b0;
            cnt_d   = ONE_C;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end else if (cnt_q == low_len) begin
          if (pend_q) begin
            cur_div_d = pend_div_q;
            ack_d     = 1'b1;
            pend_d    = 1'b0;
          end
          if (DIV_EN) begin
            clkdv_d  = 1'b1;
            rise_d   = 1'b1;
            cnt_d    = ONE_C;
            locked_d = !pend_q;
          end else begin
            state_d  = IDLE;
            clkdv_d  = 1'b0;
            cnt_d    = '0;
            locked_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end

        // Acceptance never collides with the period-end ACK since it needs pend_q=0.
        if (req_take) begin
          if (req_bad) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            pend_d     = 1'b1;
            pend_div_d = CFG_DIV;
            locked_d   = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKIN or negedge CDRST_N) begin
    if (!CDRST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DEFAULT_DIV_C;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      clkdv_q    <= 1'b0;
      rise_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clkdv_q    <= clkdv_d;
      rise_q     <= rise_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign CLKDV      = clkdv_q;
  assign CLKDV_RISE = rise_q;
  assign CFG_ACK    = ack_q;
  assign CFG_ERR    = err_q;
  assign LOCKED     = locked_q;
  assign CUR_DIV    = cur_div_q;

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  // The start-from-IDLE rise is excluded; a ratio change restarts the count.
  always_comb begin
    pcnt_d = pcnt_q;
    if (cur_div_d != cur_div_q) begin
      pcnt_d = '0;
    end else if (rise_d && (state_q == RUN)) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLKIN or negedge CDRST_N) begin
    if (!CDRST_N) pcnt_q <= '0;
    else          pcnt_q <= pcnt_d;
  end

  assign PERIOD_CNT = pcnt_q;
`endif

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Programmable clock-divider controller that generates the divided clock CLKDV from CLKIN and sequences it safely.
- Starts and stops the divided clock on whole-period boundaries only.
- Accepts divide-ratio changes through a REQ/ACK handshake and applies them without runt pulses.
- Reports lock status.
- Sits between the lab's configuration logic and every consumer of the divided clock.

Parameters:
CNT_W, 8, width of divide ratio and phase counter (max ratio 2^CNT_W-1)
DEFAULT_DIV, 10, divide ratio loaded at reset
MIN_DIV, 2, smallest legal ratio; lower requests are rejected

Ports:
CLKIN  input  1  source clock; all logic on rising edge
CDRST_N  input  1  asynchronous active-low reset
DIV_EN  input  1  level: 1 = run divided clock, 0 = stop at next period end
CFG_REQ  input  1  level: request to load CFG_DIV
CFG_DIV  input  CNT_W  requested divide ratio; stable while CFG_REQ=1
CFG_ACK  output  1  one-cycle pulse: request completed
CFG_ERR  output  1  one-cycle pulse with CFG_ACK: request rejected
CLKDV  output  1  registered divided clock
CLKDV_RISE  output  1  one-cycle pulse, high in the cycle CLKDV goes 0->1
LOCKED  output  1  CLKDV running with CUR_DIV for at least one full period
CUR_DIV  output  CNT_W  ratio currently applied

Behaviour:
- Reset (CDRST_N=0, asynchronous):
  - CLKDV, CLKDV_RISE, CFG_ACK, CFG_ERR, LOCKED = 0.
  - CUR_DIV = DEFAULT_DIV; state IDLE; phase counter = 0; pending register cleared.
- Phase lengths for ratio N:
  - High phase H = (N+1)/2 cycles; low phase L = N/2 cycles (integer division).
  - N=10 gives 5/5; N=3 gives 2/1; N=2 toggles every cycle.
- States:
  - IDLE: CLKDV=0. On the edge sampling DIV_EN=1, set CLKDV<=1, CLKDV_RISE<=1, cnt<=1, go to RUN.
  - RUN, high phase: at cnt==H, set CLKDV<=0 and cnt<=1. Otherwise cnt<=cnt+1.
  - RUN, low phase: at cnt==L, the period ends; take the period-end action. Otherwise cnt<=cnt+1.
  - Period-end action:
    - If a request is pending: CUR_DIV<=pending, pulse CFG_ACK, clear pending.
    - Then, if DIV_EN=1: CLKDV<=1, CLKDV_RISE<=1, cnt<=1, new period uses the updated CUR_DIV.
    - If DIV_EN=0: go to IDLE with CLKDV=0 (graceful stop, no truncated high phase).
- DIV_EN:
  - Deasserting mid-period never shortens the current high or low phase.
  - Reasserting before the period end cancels the stop.
- LOCKED:
  - Sets at the second CLKDV rise after start or after a ratio change, i.e. once one complete period has elapsed with CUR_DIV.
  - Clears on the edge a request is accepted in RUN, and on entering IDLE.
- CFG_REQ is sampled only while CFG_ACK=0 and no request is pending. The requester drops CFG_REQ in the cycle after CFG_ACK; a still-high CFG_REQ then counts as a new request.
- Request with CFG_DIV < MIN_DIV (any state): on the next edge, CFG_ACK=CFG_ERR=1 for one cycle; CUR_DIV unchanged; LOCKED unaffected.
- Legal request in IDLE: on the next edge, CUR_DIV<=CFG_DIV and CFG_ACK pulses.
- Legal request in RUN: latched into pending and acknowledged at the period end as above. Latency is at most one divided period plus one cycle.
- Request and DIV_EN rise on the same edge in IDLE: the new ratio is loaded and CLKDV starts on that same edge, using the new ratio.
- Reset during operation: immediate return to reset values; any pending request is dropped with no ACK.
- All counter compares are CNT_W-bit unsigned; cnt never exceeds H or L.

Optional Feature:
Macro CLKDIV_PERIOD_CNT_EN.
- Defined: adds output PERIOD_CNT (16 bits), reset 0. It increments on every CLKDV_RISE except the start-from-IDLE rise, and wraps 16'hFFFF->0. It clears whenever CUR_DIV changes.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, DIV_EN=1, default ratio 10 -> CLKDV 5 cycles high/5 low; CLKDV_RISE every 10 cycles; LOCKED=1 at the second rise (edge 11).
- IDLE, CFG_REQ with CFG_DIV=3 -> CFG_ACK on the next edge, CUR_DIV=3; then DIV_EN=1 -> CLKDV pattern 2 high/1 low.
- RUN at ratio 10, request CFG_DIV=4 during the high phase -> old period completes (5/5); ACK at that period end; LOCKED drops at acceptance; then 2/2 periods; LOCKED returns after one 4-cycle period.
- Request CFG_DIV=1 while running -> CFG_ACK and CFG_ERR together for one cycle; CUR_DIV stays 10; CLKDV undisturbed.
- RUN at ratio 10, DIV_EN=0 on cycle 2 of the high phase -> CLKDV stays high until cycle 5, low for 5, then IDLE; LOCKED=0. Repeat with DIV_EN reasserted on cycle 7 -> no stop occurs.
- Ratio 2 running, CDRST_N pulsed low mid-period with a request pending -> all outputs 0 immediately; CUR_DIV=10; no CFG_ACK after release.
